// File: rtl/ct_spsram_256x54_pkg.sv
// Shared constants and state encoding for the 256x54 single-port SRAM request controller.
package ct_spsram_256x54_pkg;

  localparam int ADDR_WIDTH     = 8;
  localparam int DATA_WIDTH     = 54;
  localparam int DEPTH          = 256;
  localparam int RSP_FIFO_DEPTH = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/ct_spsram_rsp_fifo.sv
// Two-entry in-order read-response FIFO with valid/ready output and occupancy count.
module ct_spsram_rsp_fifo
  import ct_spsram_256x54_pkg::*;
#(
  parameter int DW = DATA_WIDTH
) (
  input  logic          forever_cpuclk,
  input  logic          cpurst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          vld,
  input  logic          rdy,
  output logic [DW-1:0] data,
  output logic [1:0]    cnt
);

  logic [DW-1:0] mem [RSP_FIFO_DEPTH];
  logic          wr_ptr;
  logic          rd_ptr;
  logic          pop;

  assign vld  = (cnt != 2'd0);
  assign pop  = vld & rdy;
  assign data = mem[rd_ptr];

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      // NOTE: the two entries are reset so rsp_rdata reads zero out of reset.
      mem    <= '{default: '0};
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ct_spsram_256x54_ctrl.sv
// Request-side controller for the 256x54 LSU SRAM: zero-fill sweep after reset, then
// valid/ready reads/writes with a credit-limited two-entry read-response FIFO.
module ct_spsram_256x54_ctrl
  import ct_spsram_256x54_pkg::*;
#(
  parameter int ADDR_WIDTH = ct_spsram_256x54_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = ct_spsram_256x54_pkg::DATA_WIDTH
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst,
  output logic                  init_done,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  ctrl_state_e           state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  rd_pend;
  logic [1:0]            fifo_cnt;
  logic                  pop;
  logic [2:0]            occupancy;
  logic                  rd_credit;
  logic                  accept;

  // A read needs a free FIFO slot once every in-flight read has landed.
  assign pop       = rsp_vld & rsp_rdy;
  assign occupancy = {1'b0, fifo_cnt} + {2'b00, rd_pend} - {2'b00, pop};
  assign rd_credit = (occupancy < 3'(RSP_FIFO_DEPTH));
  assign req_rdy   = init_done & ~cpurst & (req_wr | rd_credit);
  assign accept    = req_vld & req_rdy;

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
      rd_pend   <= 1'b0;
    end else begin
      // NOTE: non-blocking assigns so every flop here updates from pre-edge values.
      rd_pend <= accept & ~req_wr;
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + 1'b1;
        if (&init_cnt) begin
          state     <= ST_RUN;
          init_done <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    // NOTE: idle defaults first so every path assigns every pin and no latch is inferred.
    sram_a    = '0;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_d    = '0;
    if (!cpurst) begin
      if (state == ST_INIT) begin
        sram_a    = init_cnt;
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
      end else if (accept) begin
        sram_a   = req_addr;
        sram_cen = 1'b0;
        if (req_wr) begin
          sram_gwen = 1'b0;
          sram_wen  = ~req_wmask;
          sram_d    = req_wdata;
        end
      end
    end
  end

  ct_spsram_rsp_fifo #(
    .DW (DATA_WIDTH)
  ) u_rsp_fifo (
    .forever_cpuclk (forever_cpuclk),
    .cpurst         (cpurst),
    .push           (rd_pend),
    .push_data      (sram_q),
    .vld            (rsp_vld),
    .rdy            (rsp_rdy),
    .data           (rsp_rdata),
    .cnt            (fifo_cnt)
  );

endmodule
